fetch_stage: RTL and testbench

- IF stage of the 5-stage RV64 pipeline. Owns the PC register and issues instruction-bus requests.
- Holds the fetched 32-bit instruction until decode accepts it, then presents one fetch_data_t per cycle to the decode stage register.
- Handles stalls from decode, memory and execute, and branch redirects, including a redirect that arrives while a bus request is still in flight.

---
 rtl/fetch_stage_pkg.sv | 36 +++
 rtl/fetch_stage_pcselect.sv | 32 +++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the IF stage: common scalar aliases, plus the fetch FSM,
// the PC-mux select and the fetch-to-decode record.
package common_pkg;
   typedef logic [63:0] u64;
   typedef logic [31:0] u32;
   typedef u64          word_t;
endpackage

package fetch_stage_pkg;
   import common_pkg::*;

   localparam u32 NOP_INSTR        = 32'h0000_0013;
   localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;

   typedef enum logic [1:0] {
      S_REQ,
      S_VALID,
      S_DROP
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_SEL_HOLD,
      PC_SEL_INC,
      PC_SEL_REDIRECT,
      PC_SEL_TARGET
   } pc_sel_t;

   typedef struct packed {
      u64   pc;
      u32   raw_instr;
      u32   iresp_data;
      logic valid;
      logic bubble;
      logic misalign;
   } fetch_data_t;
endpackage

// File: rtl/fetch_stage_pcselect.sv
// Next-PC mux for the IF stage: reset vector, redirect target, latched
// target after a dropped response, sequential +4, or hold.
module fetch_stage_pcselect
   import fetch_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
   input  logic              reset_i,
   input  pc_sel_t           sel_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_d_o
);

   // Reset dominates every other source; the +4 path wraps silently.
   always_comb begin
      pc_d_o = pc_i;
      if (reset_i) begin
         pc_d_o = PC_RESET;
      end else begin
         unique case (sel_i)
            PC_SEL_INC:      pc_d_o = pc_i + ADDR_W'(4);
            PC_SEL_REDIRECT: pc_d_o = redirect_pc_i;
            PC_SEL_TARGET:   pc_d_o = target_i;
            default:         pc_d_o = pc_i;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction-bus requests and buffers one
// instruction for decode. Define FETCH_MISALIGN_EN to trap misaligned PCs.
module fetch_stage
   import common_pkg::*;
   import fetch_stage_pkg::*;
#(
   parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int unsigned ADDR_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ireq_valid,
   output logic [ADDR_W-1:0] ireq_addr,
   input  logic              iresp_data_ok,
   input  logic [31:0]       iresp_data,
   input  logic              stop,
   input  logic              stop_formem,
   input  logic              stop_forexe,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output fetch_data_t       dataF
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [31:0]       inst_buf_q, inst_buf_d;
   pc_sel_t           pc_sel;
   logic              hold;
`ifdef FETCH_MISALIGN_EN
   logic              misalign_q, misalign_d;
`endif

   fetch_stage_pcselect #(
      .ADDR_W   (ADDR_W),
      .PC_RESET (ADDR_W'(PC_RESET))
   ) u_pcselect (
      .reset_i       (reset),
      .sel_i         (pc_sel),
      .pc_i          (pc_q),
      .redirect_pc_i (redirect_pc),
      .target_i      (target_q),
      .pc_d_o        (pc_d)
   );

   always_ff @(posedge clk) begin
      pc_q <= pc_d;
      if (reset) begin
         state_q    <= S_REQ;
         target_q   <= ADDR_W'(PC_RESET);
         inst_buf_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         inst_buf_q <= inst_buf_d;
`ifdef FETCH_MISALIGN_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // The PC only moves when the FSM leaves a state, so ireq_addr is stable
   // for the whole life of a request, including the drain in S_DROP.
   always_comb begin
      hold       = stop | stop_formem | stop_forexe;
      state_d    = state_q;
      target_d   = target_q;
      inst_buf_d = inst_buf_q;
      pc_sel     = PC_SEL_HOLD;
`ifdef FETCH_MISALIGN_EN
      misalign_d = misalign_q;
      ireq_addr  = pc_q;
`else
      ireq_addr  = {pc_q[ADDR_W-1:2], 2'b00};
`endif
      ireq_valid       = 1'b0;
      dataF            = '0;
      dataF.pc         = u64'(pc_q);
      dataF.raw_instr  = NOP_INSTR;
      dataF.iresp_data = NOP_INSTR;
      dataF.bubble     = 1'b1;

      unique case (state_q)
         S_REQ: begin
`ifdef FETCH_MISALIGN_EN
            if (pc_q[1:0] != 2'b00) begin
               if (redirect) begin
                  pc_sel = PC_SEL_REDIRECT;
               end else begin
                  inst_buf_d = NOP_INSTR;
                  misalign_d = 1'b1;
                  state_d    = S_VALID;
               end
            end else begin
`else
            begin
`endif
               ireq_valid = 1'b1;
               if (iresp_data_ok) begin
                  if (redirect) begin
                     pc_sel = PC_SEL_REDIRECT;
                  end else begin
                     inst_buf_d = iresp_data;
`ifdef FETCH_MISALIGN_EN
                     misalign_d = 1'b0;
`endif
                     state_d    = S_VALID;
                  end
               end else if (redirect) begin
                  target_d = redirect_pc;
                  state_d  = S_DROP;
               end
            end
         end

         S_VALID: begin
            if (redirect) begin
               pc_sel     = PC_SEL_REDIRECT;
               inst_buf_d = NOP_INSTR;
               state_d    = S_REQ;
            end else begin
               dataF.valid      = 1'b1;
               dataF.bubble     = 1'b0;
               dataF.raw_instr  = inst_buf_q;
               dataF.iresp_data = inst_buf_q;
`ifdef FETCH_MISALIGN_EN
               dataF.misalign   = misalign_q;
`endif
               if (!hold) begin
                  pc_sel  = PC_SEL_INC;
                  state_d = S_REQ;
               end
            end
         end

         S_DROP: begin
            ireq_valid = 1'b1;
            if (redirect) begin
               target_d = redirect_pc;
            end
            if (iresp_data_ok) begin
               pc_sel  = redirect ? PC_SEL_REDIRECT : PC_SEL_TARGET;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase

      if (reset) begin
         ireq_valid   = 1'b0;
         dataF        = '0;
         dataF.bubble = 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a latency-programmable instruction
// memory responder plus a scoreboard of instructions decode should see.
`timescale 1ns/1ps
module tb_fetch_stage;
   import common_pkg::*;
   import fetch_stage_pkg::*;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stop, stop_formem, stop_forexe;
   logic        redirect;
   logic [63:0] redirect_pc;
   fetch_data_t dataF;

   int          errors = 0;
   int          checks = 0;
   exp_t        expQ[$];
   exp_t        monExp;
   logic        presented = 1'b0;
   int          memLat;
   logic        busy;
   int          waitCnt;
   logic [63:0] respAddr;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .stop          (stop),
      .stop_formem   (stop_formem),
      .stop_forexe   (stop_forexe),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .dataF         (dataF)
   );

   function automatic logic [31:0] instrFor(input logic [63:0] a);
      return {a[19:0], 12'h093};
   endfunction

   // Each instruction is compared once, on the first cycle decode sees it.
   always @(negedge clk) begin
      if (!reset && dataF.valid === 1'b1) begin
         if (!presented) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_valid: got pc=%h instr=%h, required no valid output",
                        dataF.pc, dataF.raw_instr);
            end else begin
               monExp = expQ.pop_front();
               if (dataF.pc !== monExp.pc || dataF.raw_instr !== monExp.instr ||
                   dataF.iresp_data !== monExp.instr || dataF.misalign !== monExp.misalign ||
                   dataF.bubble !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL scoreboard: got pc=%h instr=%h mirror=%h mis=%b bub=%b, required pc=%h instr=%h mis=%b bub=0",
                           dataF.pc, dataF.raw_instr, dataF.iresp_data, dataF.misalign,
                           dataF.bubble, monExp.pc, monExp.instr, monExp.misalign);
               end
            end
         end
         presented = (stop | stop_formem | stop_forexe) & ~redirect;
      end else begin
         presented = 1'b0;
      end
   end

   // Advances one clock and plays the memory side of the bus handshake.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      if (reset) begin
         busy          = 1'b0;
         iresp_data_ok = 1'b0;
      end else begin
         if (iresp_data_ok) begin
            iresp_data_ok = 1'b0;
            busy          = 1'b0;
         end
         if (!busy && ireq_valid) begin
            busy     = 1'b1;
            waitCnt  = memLat;
            respAddr = ireq_addr;
         end
         if (busy) begin
            if (waitCnt == 0) begin
               iresp_data_ok = 1'b1;
               iresp_data    = instrFor(respAddr);
            end else begin
               waitCnt--;
            end
         end
      end
   endtask

   task automatic pushExp(input logic [63:0] pc, input logic [31:0] instr, input logic mis);
      exp_t e;
      e.pc       = pc;
      e.instr    = instr;
      e.misalign = mis;
      expQ.push_back(e);
   endtask

   task automatic waitValid(input int budget, input string what);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (dataF.valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         applyStimulus();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s_timeout: dataF.valid stayed 0 for %0d cycles, required 1", what, budget);
      end
   endtask

   task automatic waitAddr(input logic [63:0] target, input int budget, input string what);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (ireq_valid === 1'b1 && ireq_addr === target) begin
            ok = 1'b1;
            break;
         end
         applyStimulus();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s_timeout: last ireq_addr=%h valid=%b, required %h", what, ireq_addr, ireq_valid, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus();
      applyStimulus();
      #1;
      checks++;
      if (ireq_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ireq_valid: got %b, required 0", ireq_valid);
      end
      checks++;
      if (dataF.valid !== 1'b0 || dataF.bubble !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_dataF: got valid=%b bubble=%b, required valid=0 bubble=1", dataF.valid, dataF.bubble);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin
         errors++;
         $display("[TB] FAIL reset_first_req: got valid=%b addr=%h, required 1 80000000", ireq_valid, ireq_addr);
      end
   endtask

   task automatic test_fetch();
      pushExp(64'h8000_0000, 32'h0000_0093, 1'b0);
      waitValid(20, "fetch");
      checks++;
      if (dataF.raw_instr !== 32'h0000_0093) begin
         errors++;
         $display("[TB] FAIL fetch_instr: got %h, required 00000093", dataF.raw_instr);
      end
      applyStimulus();
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004 || dataF.bubble !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fetch_next_req: got valid=%b addr=%h bubble=%b, required 1 80000004 1",
                  ireq_valid, ireq_addr, dataF.bubble);
      end
   endtask

   task automatic test_hold();
      fetch_data_t held;
      pushExp(64'h8000_0004, instrFor(64'h8000_0004), 1'b0);
      waitValid(20, "hold");
      held        = dataF;
      stop_formem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         #1;
         checks++;
         if (dataF !== held || ireq_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_stable: got dataF=%h req=%b, required dataF=%h req=0", dataF, ireq_valid, held);
         end
      end
      stop_formem = 1'b0;
      applyStimulus();
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008) begin
         errors++;
         $display("[TB] FAIL hold_resume: got valid=%b addr=%h, required 1 80000008", ireq_valid, ireq_addr);
      end
   endtask

   task automatic test_redirect_inflight();
      redirect    = 1'b1;
      redirect_pc = 64'h8000_0100;
      applyStimulus();
      redirect = 1'b0;
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008 || dataF.valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drop_old_addr: got valid=%b addr=%h dvalid=%b, required 1 80000008 0",
                  ireq_valid, ireq_addr, dataF.valid);
      end
      pushExp(64'h8000_0100, instrFor(64'h8000_0100), 1'b0);
      waitAddr(64'h8000_0100, 20, "drop_target");
      waitValid(20, "drop_fetch");
   endtask

   task automatic test_redirect_hold();
      stop = 1'b1;
      applyStimulus();
      #1;
      redirect    = 1'b1;
      redirect_pc = 64'h8000_0200;
      #1;
      checks++;
      if (dataF.valid !== 1'b0 || dataF.bubble !== 1'b1 || dataF.raw_instr !== 32'h0000_0013) begin
         errors++;
         $display("[TB] FAIL redir_hold_bubble: got valid=%b bubble=%b instr=%h, required 0 1 00000013",
                  dataF.valid, dataF.bubble, dataF.raw_instr);
      end
      applyStimulus();
      redirect = 1'b0;
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200) begin
         errors++;
         $display("[TB] FAIL redir_hold_target: got valid=%b addr=%h, required 1 80000200", ireq_valid, ireq_addr);
      end
      stop = 1'b0;
      pushExp(64'h8000_0200, instrFor(64'h8000_0200), 1'b0);
      waitValid(20, "redir_hold_fetch");
   endtask

   task automatic test_redirect_dataok();
      bit found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         #1;
         if (iresp_data_ok === 1'b1 && ireq_addr === 64'h8000_0204) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL dataok_wait_timeout: no response at 80000204, last addr=%h", ireq_addr);
      end
      redirect    = 1'b1;
      redirect_pc = 64'h8000_0300;
      applyStimulus();
      redirect = 1'b0;
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300 || dataF.valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dataok_redirect: got valid=%b addr=%h dvalid=%b, required 1 80000300 0",
                  ireq_valid, ireq_addr, dataF.valid);
      end
      pushExp(64'h8000_0300, instrFor(64'h8000_0300), 1'b0);
      waitValid(20, "dataok_fetch");
   endtask

   task automatic test_back_to_back();
      logic [63:0] a;
      memLat = 0;
      for (int k = 1; k <= 4; k++) begin
         a = 64'h8000_0300 + 64'(4 * k);
         pushExp(a, instrFor(a), 1'b0);
         applyStimulus();
         #1;
         checks++;
         if (ireq_valid !== 1'b1 || ireq_addr !== a || dataF.bubble !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_req: got valid=%b addr=%h bubble=%b, required 1 %h 1",
                     ireq_valid, ireq_addr, dataF.bubble, a);
         end
         waitValid(10, "b2b");
         if (k == 2) begin
            stop_forexe = 1'b1;
            applyStimulus();
            #1;
            checks++;
            if (dataF.valid !== 1'b1 || dataF.pc !== a) begin
               errors++;
               $display("[TB] FAIL exe_hold: got valid=%b pc=%h, required 1 %h", dataF.valid, dataF.pc, a);
            end
            stop_forexe = 1'b0;
         end
      end
      memLat = 2;
   endtask

   task automatic test_wrap();
      applyStimulus();
      redirect    = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      applyStimulus();
      redirect = 1'b0;
      pushExp(64'hFFFF_FFFF_FFFF_FFFC, instrFor(64'hFFFF_FFFF_FFFF_FFFC), 1'b0);
      waitAddr(64'hFFFF_FFFF_FFFF_FFFC, 20, "wrap_target");
      waitValid(20, "wrap_fetch");
      applyStimulus();
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin
         errors++;
         $display("[TB] FAIL pc_wrap: got valid=%b addr=%h, required 1 0000000000000000", ireq_valid, ireq_addr);
      end
      pushExp(64'h0, instrFor(64'h0), 1'b0);
      waitValid(20, "wrap_zero");
   endtask

   task automatic test_misalign();
      stop = 1'b1;
      applyStimulus();
      #1;
      redirect    = 1'b1;
      redirect_pc = 64'h8000_0102;
      applyStimulus();
      redirect = 1'b0;
      stop     = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_EN
      checks++;
      if (ireq_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL misalign_no_req: got ireq_valid=%b, required 0", ireq_valid);
      end
      pushExp(64'h8000_0102, 32'h0000_0013, 1'b1);
      waitValid(20, "misalign");
      checks++;
      if (dataF.misalign !== 1'b1 || dataF.raw_instr !== 32'h0000_0013) begin
         errors++;
         $display("[TB] FAIL misalign_flag: got mis=%b instr=%h, required 1 00000013", dataF.misalign, dataF.raw_instr);
      end
`else
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100) begin
         errors++;
         $display("[TB] FAIL align_force: got valid=%b addr=%h, required 1 80000100", ireq_valid, ireq_addr);
      end
      pushExp(64'h8000_0102, instrFor(64'h8000_0100), 1'b0);
      waitValid(20, "align");
      checks++;
      if (dataF.misalign !== 1'b0) begin
         errors++;
         $display("[TB] FAIL misalign_tied: got %b, required 0", dataF.misalign);
      end
`endif
      applyStimulus();
      redirect    = 1'b1;
      redirect_pc = 64'h8000_0400;
      applyStimulus();
      redirect = 1'b0;
      pushExp(64'h8000_0400, instrFor(64'h8000_0400), 1'b0);
      waitAddr(64'h8000_0400, 20, "misalign_exit");
      waitValid(20, "misalign_exit_fetch");
   endtask

   task automatic test_reset_midreq();
      applyStimulus();
      reset = 1'b1;
      #1;
      checks++;
      if (ireq_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreq_reset_req: got %b, required 0", ireq_valid);
      end
      applyStimulus();
      reset = 1'b0;
      #1;
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin
         errors++;
         $display("[TB] FAIL midreq_restart: got valid=%b addr=%h, required 1 80000000", ireq_valid, ireq_addr);
      end
      pushExp(64'h8000_0000, 32'h0000_0093, 1'b0);
      waitValid(20, "midreq_fetch");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'h0;
      stop          = 1'b0;
      stop_formem   = 1'b0;
      stop_forexe   = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = 64'h0;
      memLat        = 2;
      busy          = 1'b0;
      waitCnt       = 0;
      respAddr      = 64'h0;

      test_reset();
      test_fetch();
      test_hold();
      test_redirect_inflight();
      test_redirect_hold();
      test_redirect_dataok();
      test_back_to_back();
      test_wrap();
      test_misalign();
      test_reset_midreq();

      applyStimulus();
      applyStimulus();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL leftover_expected: got %0d pending, required 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
